serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock through a single full-subtractor cell.
- It is the subtract-direction counterpart to the team's ripple-carry adder: borrow takes the place of carry, and one cell is reused over time instead of chaining WIDTH cells.
- It sits beside the adder datapath as an area-cheap ALU subtract unit and uses a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 13 +
 rtl/fs_bit.sv | 21 ++
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and serial-unit FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor cell: d = x - y - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
// Ports: x (minuend bit), y (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic xy;

  assign xy   = x ^ y;
  assign d    = xy ^ bin;
  // Borrow when x=0,y=1, or when x==y and a borrow is already pending.
  assign bout = (~x & y) | (~xy & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor diff = a - b, LSB first through one fs_bit cell.
// Latency: WIDTH cycles from the accepted start edge to the done pulse.
// Backpressure: start is ignored while busy; no queuing, caller must wait for done.
// Ports: clk, rst (sync, active-high), start, a, b (captured on accepted start),
//        diff/bout (registered result, held between completions), busy, done (1-cycle pulse).
module serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] acc;
  logic             borrow;
  logic [CNT_W-1:0] count;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] acc_nxt;

  fs_bit u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (borrow),
    .d    (cell_d),
    .bout (cell_bo)
  );

  // Difference bits enter at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
  assign acc_nxt = {cell_d, acc[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            acc    <= '0;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          acc    <= acc_nxt;
          borrow <= cell_bo;
          count  <= count + CNT_W'(1);
          if (count == LAST) begin
            // Last bit: publish result straight from the cell outputs.
            diff  <= acc_nxt;
            bout  <= cell_bo;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         busy;
  logic         done;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .diff  (diff),
    .bout  (bout),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("bout", 32'(bout), 32'(e.bo));
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at a negedge; start is seen at the next posedge, done W edges later.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic expect_result);
    exp_t e;
    start = 1'b1;
    a     = av;
    b     = bv;
    if (expect_result) begin
      e.d   = av - bv;
      e.bo  = (av < bv);
      e.cyc = cyc + 1 + W;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  logic [W-1:0] vec_a [4] = '{8'd5, 8'd0, 8'hA5, 8'hFF};
  logic [W-1:0] vec_b [4] = '{8'd9, 8'd1, 8'hA5, 8'h00};
  logic [W-1:0] vec_d [4] = '{8'hFC, 8'hFF, 8'h00, 8'hFF};
  logic         vec_o [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;

    // Reset and idle.
    repeat (2) begin
      @(negedge clk);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("idle_bout", 32'(bout), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Basic 100 - 37 with busy window check.
    issue(8'd100, 8'd37, 1'b1);
    chk("basic_hand_exp", 32'(q[0].d), 32'd63);
    for (int i = 0; i < W; i++) begin
      chk("basic_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("basic_busy_end", 32'(busy), 32'd0);
    chk("basic_done", 32'(done), 32'd1);
    wait_drain();

    // Hand-computed borrow and boundary vectors.
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      start = 1'b1;
      a     = vec_a[i];
      b     = vec_b[i];
      e.d   = vec_d[i];
      e.bo  = vec_o[i];
      e.cyc = cyc + 1 + W;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      wait_drain();
    end

    // Start ignored mid-run, then back-to-back start in the done cycle.
    issue(8'd200, 8'd50, 1'b1);
    repeat (2) @(negedge clk);
    issue(8'd1, 8'd2, 1'b0);
    n = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    chk("ign_done_seen", 32'(done), 32'd1);
    chk("ign_diff", 32'(diff), 32'd150);
    issue(8'd3, 8'd4, 1'b1);
    for (int i = 0; i < W - 1; i++) begin
      chk("hold_diff", 32'(diff), 32'd150);
      @(negedge clk);
    end
    wait_drain();
    chk("b2b_diff", 32'(diff), 32'hFF);
    chk("b2b_bout", 32'(bout), 32'd1);

    // Reset during RUN aborts with no done pulse.
    issue(8'd10, 8'd3, 1'b0);
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    repeat (2 * W) @(negedge clk);
    chk("abort_still_idle", 32'(busy), 32'd0);
    issue(8'd10, 8'd3, 1'b1);
    wait_drain();
    chk("fresh_diff", 32'(diff), 32'd7);

    // Random regression against arithmetic expectation.
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'b1);
      wait_drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
